// File: rtl/gdo.sv
// Shared types and constants for the general data operator family.
package gdo;

  localparam int gdo_data_size = 16;
  localparam int gdo_size      = 8;

  typedef logic signed [gdo_data_size-1:0] gdo_word_t;

  localparam gdo_word_t gdo_word_max = 16'sh7FFF;
  localparam gdo_word_t gdo_word_min = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN,
    DONE
  } gdo_div_state_t;

endpackage

// File: rtl/gdo_divider.sv
// Sequential signed fixed-point divider: q = a / b in Q(DATA_W-FRAC_W).FRAC_W.
// Restoring division on magnitudes, one quotient bit per clock, sign applied
// and saturated at the end. Truncates toward zero.
//
// state | meaning
// IDLE  | ready for operands
// CALC  | one restoring step per cycle, ITER cycles
// FIN   | apply sign, saturate, register result (divide-by-zero skips CALC)
// DONE  | result valid, held until out_ready
module gdo_divider
  import gdo::*;
#(
  parameter int DATA_W = gdo_data_size,
  parameter int FRAC_W = gdo_size
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_q,
  output logic              out_ovf,
  output logic              out_dz
);

  localparam int ITER  = DATA_W + FRAC_W;
  // One extra bit so |most negative| is representable.
  localparam int MAG_W = DATA_W + 1;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [ITER-1:0]   Q_POS_LIM = ITER'((64'd1 << (DATA_W-1)) - 64'd1);
  localparam logic [ITER-1:0]   Q_NEG_LIM = ITER'(64'd1 << (DATA_W-1));
  localparam logic [DATA_W-1:0] W_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] W_MIN     = {1'b1, {(DATA_W-1){1'b0}}};

  gdo_div_state_t state, state_nxt;

  logic              rdy_en;
  logic              sign_r;
  logic              a_neg_r;
  logic              dz_r;
  logic [MAG_W-1:0]  b_mag;
  logic [ITER-1:0]   dvd;
  logic [ITER-1:0]   quo;
  logic [MAG_W-1:0]  rem;
  logic [CNT_W-1:0]  cnt;

  logic [MAG_W-1:0]  a_ext, b_ext, a_abs, b_abs;
  logic [MAG_W:0]    rem_sh;
  logic [MAG_W-1:0]  rem_nxt;
  logic              qbit;
  logic [DATA_W-1:0] fin_q;
  logic              fin_ovf;
  logic              accept;

  assign a_ext = {in_a[DATA_W-1], in_a};
  assign b_ext = {in_b[DATA_W-1], in_b};
  assign a_abs = in_a[DATA_W-1] ? (~a_ext + MAG_W'(1)) : a_ext;
  assign b_abs = in_b[DATA_W-1] ? (~b_ext + MAG_W'(1)) : b_ext;

  // in_ready stays low through reset and until the first edge after release.
  assign in_ready  = rdy_en && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Ready enable: set by the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (in_b == '0) ? FIN : CALC;
      CALC: if (cnt == CNT_W'(ITER-1)) state_nxt = FIN;
      FIN:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring step: shift in the next dividend bit, subtract |b| if it fits.
  always_comb begin
    rem_sh  = {rem, dvd[ITER-1]};
    rem_nxt = rem_sh[MAG_W-1:0];
    qbit    = 1'b0;
    if (rem_sh >= {1'b0, b_mag}) begin
      rem_nxt = MAG_W'(rem_sh - {1'b0, b_mag});
      qbit    = 1'b1;
    end
  end

  // Sign application and saturation of the magnitude quotient.
  always_comb begin
    fin_q   = quo[DATA_W-1:0];
    fin_ovf = 1'b0;
    if (sign_r) begin
      if (quo > Q_NEG_LIM) begin
        fin_q   = W_MIN;
        fin_ovf = 1'b1;
      end else begin
        fin_q = ~quo[DATA_W-1:0] + DATA_W'(1);
      end
    end else if (quo > Q_POS_LIM) begin
      fin_q   = W_MAX;
      fin_ovf = 1'b1;
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      a_neg_r <= 1'b0;
      dz_r    <= 1'b0;
      b_mag   <= '0;
      dvd     <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      out_q   <= '0;
      out_ovf <= 1'b0;
      out_dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_r  <= in_a[DATA_W-1] ^ in_b[DATA_W-1];
          a_neg_r <= in_a[DATA_W-1];
          dz_r    <= (in_b == '0);
          b_mag   <= b_abs;
          dvd     <= ITER'(a_abs) << FRAC_W;
          quo     <= '0;
          rem     <= '0;
          cnt     <= '0;
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= {quo[ITER-2:0], qbit};
          dvd <= dvd << 1;
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          if (dz_r) begin
            out_q   <= a_neg_r ? W_MIN : W_MAX;
            out_ovf <= 1'b0;
            out_dz  <= 1'b1;
          end else begin
            out_q   <= fin_q;
            out_ovf <= fin_ovf;
            out_dz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
